fft_seq_ctrl: RTL

Pass sequencer for the 64-point FFT core. It drives the address generation unit's control inputs (`en_fft`, `readmem_en`, `memwrite_en`) so that each butterfly pass gets exactly 8 read cycles and 8 write cycles across the 8 memory banks. It sits between the host start/done handshake and the AGU/butterfly datapath. It holds write-back until the butterfly pipeline has drained, and does not start pass 1 reads until every pass 0 write has completed.

---
 rtl/fft_seq_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fft_seq_ctrl.sv
// Pass sequencer for the 64-point FFT: issues 8 reads and 8 writes per butterfly pass and
// keeps pass 1 reads behind the last pass 0 write-back.
module fft_seq_ctrl #(
    parameter int BFLY_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       en_fft,
    output logic       readmem_en,
    output logic       memwrite_en,
    output logic [2:0] rd_idx,
    output logic       rd_stage,
    output logic [2:0] wr_idx,
    output logic       wr_stage
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RD0,
        WAIT0,
        RD1,
        WAIT1,
        DONE_ST
    } state_t;

    state_t     state;
    logic [3:0] wr_cnt;
    logic [3:0] wr_cnt_nxt;
    logic       pass_written;

    // Read strobe/stage/index travel together as {readmem_en, rd_stage, rd_idx}.
    logic [4:0] dly [BFLY_LAT];

    assign memwrite_en = dly[BFLY_LAT-1][4];
    assign wr_stage    = dly[BFLY_LAT-1][3];
    assign wr_idx      = dly[BFLY_LAT-1][2:0];

    // The eighth write of a pass is the one completing in the current cycle.
    always_comb begin
        wr_cnt_nxt   = wr_cnt + {3'b000, memwrite_en};
        pass_written = (wr_cnt_nxt == 4'd8);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            en_fft     <= 1'b0;
            readmem_en <= 1'b0;
            rd_idx     <= '0;
            rd_stage   <= 1'b0;
            // NOTE: the delay line is reset too; a stale write strobe after a mid-pass
            // reset would advance the AGU write address of the next transform.
            for (int i = 0; i < BFLY_LAT; i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= {readmem_en, rd_stage, rd_idx};
            for (int i = 1; i < BFLY_LAT; i++) begin
                dly[i] <= dly[i-1];
            end

            wr_cnt <= wr_cnt_nxt;
            en_fft <= 1'b0;
            done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CLR;
                        busy   <= 1'b1;
                        en_fft <= 1'b1;
                    end
                end
                CLR: begin
                    wr_cnt     <= '0;
                    state      <= RD0;
                    readmem_en <= 1'b1;
                    rd_idx     <= '0;
                    rd_stage   <= 1'b0;
                end
                RD0: begin
                    if (rd_idx == 3'd7) begin
                        state      <= WAIT0;
                        readmem_en <= 1'b0;
                        rd_idx     <= '0;
                    end else begin
                        rd_idx <= rd_idx + 3'd1;
                    end
                end
                WAIT0: begin
                    if (pass_written) begin
                        state      <= RD1;
                        wr_cnt     <= '0;
                        readmem_en <= 1'b1;
                        rd_stage   <= 1'b1;
                    end
                end
                RD1: begin
                    if (rd_idx == 3'd7) begin
                        state      <= WAIT1;
                        readmem_en <= 1'b0;
                        rd_stage   <= 1'b0;
                        rd_idx     <= '0;
                    end else begin
                        rd_idx <= rd_idx + 3'd1;
                    end
                end
                WAIT1: begin
                    if (pass_written) begin
                        state <= DONE_ST;
                        done  <= 1'b1;
                    end
                end
                DONE_ST: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    readmem_en <= 1'b0;
                    rd_stage   <= 1'b0;
                    rd_idx     <= '0;
                end
            endcase
        end
    end

endmodule
